// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM counter/compare engine.
//   - default widths for the counter and the dead-time count
//   - the engine state encoding
//   - register offsets and ctrl bit indices of the pwm_gen register file,
//     kept here so the register front end and the core agree on them
// Optional feature macro used by the core: PWM_DEADTIME_EN.
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DT_W_DEF  = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_e;

    localparam logic [3:0] REG_CTRL_OFS     = 4'h0;
    localparam logic [3:0] REG_PERIOD_OFS   = 4'h4;
    localparam logic [3:0] REG_DUTY_OFS     = 4'h8;
    localparam logic [3:0] REG_DEADTIME_OFS = 4'hC;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_LOAD_BIT   = 1;

endpackage

// File: rtl/pwm_deadband.sv
// -----------------------------------------------------------------------------
// pwm_deadband
// Splits one raw PWM level into a high-side / low-side pair with a dead band.
// Whenever the raw level changes, both outputs go low and the newly active
// side is held off for 'dt' cycles. A raw pulse shorter than the band never
// reaches an output because every change reloads the delay.
// Only instantiated when PWM_DEADTIME_EN is defined.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   srst   in   synchronous clear (held while the engine is idle)
//   raw    in   raw compare level, aligned with the counter value it belongs to
//   dt     in   dead-band length in cycles
//   hi     out  registered high-side output
//   lo     out  registered low-side output
// -----------------------------------------------------------------------------
module pwm_deadband #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            srst,
    input  logic            raw,
    input  logic [DT_W-1:0] dt,
    output logic            hi,
    output logic            lo
);

    localparam logic [DT_W-1:0] DLY_ONE = {{(DT_W-1){1'b0}}, 1'b1};

    logic            raw_q_r;
    logic [DT_W-1:0] dly_r;
    logic [DT_W-1:0] dly_s;
    logic            hi_s;
    logic            lo_s;

    // Dead-band delay: reload on every raw change, otherwise count down to 0
    always_comb begin
        dly_s = '0;
        if (raw != raw_q_r) begin
            dly_s = dt;
        end else if (dly_r != '0) begin
            dly_s = dly_r - DLY_ONE;
        end else begin
            dly_s = '0;
        end
        hi_s = raw & (dly_s == '0);
        lo_s = ~raw & (dly_s == '0);
    end

    // Output and delay registers; idle clears so a restart always sees a band
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q_r <= 1'b0;
            dly_r   <= '0;
            hi      <= 1'b0;
            lo      <= 1'b0;
        end else if (srst) begin
            raw_q_r <= 1'b0;
            dly_r   <= '0;
            hi      <= 1'b0;
            lo      <= 1'b0;
        end else begin
            raw_q_r <= raw;
            dly_r   <= dly_s;
            hi      <= hi_s;
            lo      <= lo_s;
        end
    end

endmodule

// File: rtl/pwm_core.sv
// -----------------------------------------------------------------------------
// pwm_core
// Counter/compare engine behind the pwm_gen register file. Produces a
// complementary PWM pair from shadowed period/duty values; new values only
// take effect at a period boundary (or straight away while idle).
// Optional feature: PWM_DEADTIME_EN adds cfg_deadtime and a dead band
// between the two outputs (pwm_deadband instance).
// Ports:
//   ACLK          in   clock, rising edge
//   ARESETN       in   asynchronous active-low reset
//   cfg_enable    in   1 = run, 0 = idle
//   cfg_load      in   one-cycle pulse, capture cfg_period/cfg_duty
//   cfg_period    in   terminal count (period = cfg_period+1 cycles)
//   cfg_duty      in   high cycles per period
//   cfg_deadtime  in   dead band in cycles (PWM_DEADTIME_EN only)
//   pwm_out       out  registered high-side output
//   pwm_out_n     out  registered low-side output
//   period_start  out  one-cycle pulse at counter value 0 in RUN
//   load_pending  out  captured values not yet applied
//   cnt_value     out  current counter value
// -----------------------------------------------------------------------------
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_enable,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]  cfg_deadtime,
`endif
    output logic             pwm_out,
    output logic             pwm_out_n,
    output logic             period_start,
    output logic             load_pending,
    output logic [CNT_W-1:0] cnt_value
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pwm_state_e       state_r;
    pwm_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] period_a_r;
    logic [CNT_W-1:0] period_a_s;
    logic [CNT_W-1:0] duty_a_r;
    logic [CNT_W-1:0] duty_a_s;
    logic [CNT_W-1:0] period_p_r;
    logic [CNT_W-1:0] period_p_s;
    logic [CNT_W-1:0] duty_p_r;
    logic [CNT_W-1:0] duty_p_s;
    logic             pend_r;
    logic             pend_s;
    logic             pstart_r;
    logic             boundary_s;
    logic             run_s;
    logic             raw_s;
    logic             pstart_s;

    assign cnt_value    = cnt_r;
    assign load_pending = pend_r;
    assign period_start = pstart_r;

    // Next-state, counter and shadow-register logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        period_a_s = period_a_r;
        duty_a_s   = duty_a_r;
        period_p_s = period_p_r;
        duty_p_s   = duty_p_r;
        pend_s     = pend_r;
        boundary_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                // Entry uses the currently active period; a zero period never starts
                if (cfg_enable && (period_a_r != '0)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A zero period can only arrive through a load; fall back to idle
                if (!cfg_enable || (period_a_r == '0)) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else if (cnt_r == period_a_r) begin
                    state_s    = ST_RUN;
                    cnt_s      = '0;
                    boundary_s = 1'b1;
                end else begin
                    state_s = ST_RUN;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase

        // A load on the terminal-count cycle bypasses the pending shadow
        if (cfg_load && boundary_s) begin
            period_a_s = cfg_period;
            duty_a_s   = cfg_duty;
            pend_s     = 1'b0;
        end else begin
            if (pend_r && (boundary_s || (state_r != ST_RUN))) begin
                period_a_s = period_p_r;
                duty_a_s   = duty_p_r;
                pend_s     = 1'b0;
            end else begin
                period_a_s = period_a_r;
                duty_a_s   = duty_a_r;
            end
            // Newest load always wins over an older pending one
            if (cfg_load) begin
                period_p_s = cfg_period;
                duty_p_s   = cfg_duty;
                pend_s     = 1'b1;
            end else begin
                period_p_s = period_p_r;
                duty_p_s   = duty_p_r;
            end
        end

        // Compare on next-cycle values so the registered output lines up with cnt_value
        run_s    = (state_s == ST_RUN);
        raw_s    = run_s & (cnt_s < duty_a_s);
        pstart_s = run_s & (cnt_s == '0);
    end

    // State, counter and shadow registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            period_a_r <= '0;
            duty_a_r   <= '0;
            period_p_r <= '0;
            duty_p_r   <= '0;
            pend_r     <= 1'b0;
            pstart_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            period_a_r <= period_a_s;
            duty_a_r   <= duty_a_s;
            period_p_r <= period_p_s;
            duty_p_r   <= duty_p_s;
            pend_r     <= pend_s;
            pstart_r   <= pstart_s;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0] dt_r;
    logic [DT_W-1:0] dt_s;
    logic            idle_s;

    // Dead-band length is only picked up at the start of a period
    always_comb begin
        idle_s = ~run_s;
        if (pstart_s) begin
            dt_s = cfg_deadtime;
        end else begin
            dt_s = dt_r;
        end
    end

    // Sampled dead-band length register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dt_r <= '0;
        end else begin
            dt_r <= dt_s;
        end
    end

    pwm_deadband #(
        .DT_W (DT_W)
    ) u_deadband (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .srst  (idle_s),
        .raw   (raw_s),
        .dt    (dt_s),
        .hi    (pwm_out),
        .lo    (pwm_out_n)
    );
`else
    // Complementary output pair, both low while idle
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            pwm_out   <= raw_s;
            pwm_out_n <= run_s & ~raw_s;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_core.sv
// -----------------------------------------------------------------------------
// tb_pwm_core
// Directed self-checking bench for pwm_core. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_pwm_core;

    logic        ACLK;
    logic        ARESETN;
    logic        cfg_enable;
    logic        cfg_load;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
`ifdef PWM_DEADTIME_EN
    logic [7:0]  cfg_deadtime;
`endif
    logic        pwm_out;
    logic        pwm_out_n;
    logic        period_start;
    logic        load_pending;
    logic [15:0] cnt_value;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_core dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_enable   (cfg_enable),
        .cfg_load     (cfg_load),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
`ifdef PWM_DEADTIME_EN
        .cfg_deadtime (cfg_deadtime),
`endif
        .pwm_out      (pwm_out),
        .pwm_out_n    (pwm_out_n),
        .period_start (period_start),
        .load_pending (load_pending),
        .cnt_value    (cnt_value)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Stop, load period/duty while idle, then enable: returns sampled at cnt 0
    task automatic start_run(input logic [15:0] p, input logic [15:0] d);
        cfg_enable = 1'b0;
        tick();
        tick();
        cfg_period = p;
        cfg_duty   = d;
        cfg_load   = 1'b1;
        tick();
        cfg_load   = 1'b0;
        tick();
        cfg_enable = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        ARESETN    = 1'b0;
        cfg_enable = 1'b0;
        cfg_load   = 1'b0;
        cfg_period = 16'd0;
        cfg_duty   = 16'd0;
`ifdef PWM_DEADTIME_EN
        cfg_deadtime = 8'd0;
`endif
        repeat (2) @(posedge ACLK);
        #1;
        n_checks++;
        if ({pwm_out, pwm_out_n, period_start, load_pending} !== 4'b0000 || cnt_value !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pwm=%b n=%b ps=%b lp=%b cnt=%0d, want all 0",
                     pwm_out, pwm_out_n, period_start, load_pending, cnt_value);
        end
        ARESETN = 1'b1;
        // Enabling with a zero active period must not start the counter
        cfg_enable = 1'b1;
        tick();
        tick();
        n_checks++;
        if (period_start !== 1'b0 || cnt_value !== 16'd0 || pwm_out_n !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_period_idle: got ps=%b cnt=%0d n=%b, want 0 0 0",
                     period_start, cnt_value, pwm_out_n);
        end
        cfg_enable = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic exp_pwm;
        start_run(16'd9, 16'd3);
        for (int i = 0; i < 30; i++) begin
            exp_pwm = ((i % 10) < 3);
            n_checks++;
            if (cnt_value !== 16'(i % 10) || pwm_out !== exp_pwm || pwm_out_n !== !exp_pwm
                || period_start !== ((i % 10) == 0)) begin
                n_fail++;
                $display("FAIL basic[%0d]: got cnt=%0d pwm=%b n=%b ps=%b, want cnt=%0d pwm=%b n=%b ps=%b",
                         i, cnt_value, pwm_out, pwm_out_n, period_start,
                         i % 10, exp_pwm, !exp_pwm, (i % 10) == 0);
            end
            tick();
        end
    endtask

    task automatic test_reload;
        start_run(16'd9, 16'd3);
        repeat (4) tick();
        cfg_duty = 16'd7;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int k = 5; k < 10; k++) begin
            n_checks++;
            if (cnt_value !== 16'(k) || load_pending !== 1'b1 || pwm_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reload_pending[%0d]: got cnt=%0d lp=%b pwm=%b, want cnt=%0d lp=1 pwm=0",
                         k, cnt_value, load_pending, pwm_out, k);
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (cnt_value !== 16'(i % 10) || load_pending !== 1'b0 || pwm_out !== ((i % 10) < 7)) begin
                n_fail++;
                $display("FAIL reload_applied[%0d]: got cnt=%0d lp=%b pwm=%b, want cnt=%0d lp=0 pwm=%b",
                         i, cnt_value, load_pending, pwm_out, i % 10, (i % 10) < 7);
            end
            tick();
        end
    endtask

    task automatic test_duty_edges;
        start_run(16'd9, 16'd0);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (pwm_out !== 1'b0 || pwm_out_n !== 1'b1) begin
                n_fail++;
                $display("FAIL duty_zero[%0d]: got pwm=%b n=%b, want pwm=0 n=1", i, pwm_out, pwm_out_n);
            end
            tick();
        end
        start_run(16'd9, 16'd20);
        for (int i = 0; i < 25; i++) begin
            n_checks++;
            if (pwm_out !== 1'b1 || pwm_out_n !== 1'b0 || period_start !== ((i % 10) == 0)) begin
                n_fail++;
                $display("FAIL duty_full[%0d]: got pwm=%b n=%b ps=%b, want pwm=1 n=0 ps=%b",
                         i, pwm_out, pwm_out_n, period_start, (i % 10) == 0);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        int highs;
        start_run(16'd9, 16'd3);
        repeat (2) tick();
        cfg_duty = 16'd5;
        cfg_load = 1'b1;
        tick();
        n_checks++;
        if (load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_pending: got lp=%b, want 1", load_pending);
        end
        cfg_duty = 16'd6;
        tick();
        cfg_load = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (cnt_value !== 16'd0 || load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_boundary: got cnt=%0d lp=%b, want cnt=0 lp=0", cnt_value, load_pending);
        end
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (pwm_out === 1'b1) highs++;
            tick();
        end
        n_checks++;
        if (highs != 6) begin
            n_fail++;
            $display("FAIL b2b_high_count: got %0d high cycles, want 6", highs);
        end
    endtask

    task automatic test_tc_load;
        start_run(16'd9, 16'd3);
        repeat (9) tick();
        n_checks++;
        if (cnt_value !== 16'd9) begin
            n_fail++;
            $display("FAIL tc_cnt: got cnt=%0d, want 9", cnt_value);
        end
        cfg_duty = 16'd2;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cnt_value !== 16'(i) || load_pending !== 1'b0 || pwm_out !== (i < 2)) begin
                n_fail++;
                $display("FAIL tc_load[%0d]: got cnt=%0d lp=%b pwm=%b, want cnt=%0d lp=0 pwm=%b",
                         i, cnt_value, load_pending, pwm_out, i, i < 2);
            end
            tick();
        end
    endtask

    task automatic test_enable_drop;
        start_run(16'd9, 16'd3);
        repeat (5) tick();
        cfg_enable = 1'b0;
        cfg_duty   = 16'd8;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        n_checks++;
        if ({pwm_out, pwm_out_n, period_start} !== 3'b000 || cnt_value !== 16'd0 || load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_idle: got pwm=%b n=%b ps=%b cnt=%0d lp=%b, want 0 0 0 0 1",
                     pwm_out, pwm_out_n, period_start, cnt_value, load_pending);
        end
        tick();
        n_checks++;
        if (load_pending !== 1'b0 || pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_apply: got lp=%b pwm=%b, want lp=0 pwm=0", load_pending, pwm_out);
        end
        cfg_enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cnt_value !== 16'(i) || period_start !== (i == 0) || pwm_out !== (i < 8)) begin
                n_fail++;
                $display("FAIL restart[%0d]: got cnt=%0d ps=%b pwm=%b, want cnt=%0d ps=%b pwm=%b",
                         i, cnt_value, period_start, pwm_out, i, i == 0, i < 8);
            end
            tick();
        end
    endtask

    task automatic test_async_reset;
        start_run(16'd9, 16'd3);
        repeat (2) tick();
        #2;
        ARESETN = 1'b0;
        #1;
        n_checks++;
        if ({pwm_out, pwm_out_n, period_start, load_pending} !== 4'b0000 || cnt_value !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got pwm=%b n=%b ps=%b lp=%b cnt=%0d, want all 0",
                     pwm_out, pwm_out_n, period_start, load_pending, cnt_value);
        end
        #2;
        ARESETN = 1'b1;
        tick();
        n_checks++;
        if (cnt_value !== 16'd0 || period_start !== 1'b0 || pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got cnt=%0d ps=%b pwm=%b, want 0 0 0",
                     cnt_value, period_start, pwm_out);
        end
        cfg_enable = 1'b0;
        tick();
    endtask

`ifdef PWM_DEADTIME_EN
    task automatic test_deadtime;
        logic exp_hi;
        logic exp_lo;
        cfg_deadtime = 8'd2;
        start_run(16'd9, 16'd4);
        for (int i = 0; i < 20; i++) begin
            exp_hi = ((i % 10) >= 2) && ((i % 10) < 4);
            exp_lo = ((i % 10) >= 6);
            n_checks++;
            if (pwm_out !== exp_hi || pwm_out_n !== exp_lo) begin
                n_fail++;
                $display("FAIL deadtime[%0d]: got hi=%b lo=%b, want hi=%b lo=%b",
                         i, pwm_out, pwm_out_n, exp_hi, exp_lo);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_duty_edges();
        test_back_to_back();
        test_tc_load();
        test_enable_drop();
        test_async_reset();
`ifdef PWM_DEADTIME_EN
        test_deadtime();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
